// File: rtl/radar_pkg.sv
// Shared definitions for the radar interface receiver: azimuth width,
// ACP count per revolution and the azimuth tracker state type.
package radar_pkg;

  localparam int AZ_W        = 12;
  localparam int ACP_PER_REV = 4096;

  localparam logic [AZ_W-1:0] AZ_LAST = 12'(ACP_PER_REV - 1);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } trk_state_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus rising-edge detector for one asynchronous input.
// The pulse is blanked until the chain holds post-reset samples only.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic pulse_o
);

  logic       meta_q;
  logic       sync_q;
  logic       prev_q;
  logic [1:0] settle_q;

  // Settle counter keeps a level already high at reset release from looking like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      prev_q   <= 1'b0;
      settle_q <= 2'd0;
    end else begin
      meta_q <= din_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      if (settle_q != 2'd3) begin
        settle_q <= settle_q + 2'd1;
      end else begin
        settle_q <= settle_q;
      end
    end
  end

  assign pulse_o = sync_q & ~prev_q & (settle_q == 2'd3);

endmodule

// File: rtl/radar_if_rx.sv
// Radar interface receiver: ARP/ACP azimuth tracker with ACP-loss timeout,
// trigger-driven range-bin sweep and optional ACP period measurement
// (enabled by defining RADAR_RX_PERIOD_MEAS_EN).
module radar_if_rx
  import radar_pkg::*;
#(
  parameter int RANGE_DIV   = 24,
  parameter int RANGE_BINS  = 1000,
  parameter int ACP_TIMEOUT = 49000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            arp,
  input  logic            acp,
  input  logic            trig,
  output logic            locked,
  output logic [AZ_W-1:0] azimuth,
  output logic            sweep_start,
  output logic [AZ_W-1:0] sweep_az,
  output logic [9:0]      range_bin,
  output logic            range_valid,
  output logic            rev_err,
  output logic            acp_lost,
  output logic [15:0]     acp_period
);

  localparam logic [15:0] DIV_LAST     = 16'(RANGE_DIV - 1);
  localparam logic [9:0]  BIN_LAST     = 10'(RANGE_BINS - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(ACP_TIMEOUT - 1);

  logic arp_ev;
  logic acp_ev;
  logic trig_ev;

  edge_sync u_arp_sync  (.clk(clk), .rst(rst), .din_i(arp),  .pulse_o(arp_ev));
  edge_sync u_acp_sync  (.clk(clk), .rst(rst), .din_i(acp),  .pulse_o(acp_ev));
  edge_sync u_trig_sync (.clk(clk), .rst(rst), .din_i(trig), .pulse_o(trig_ev));

  trk_state_t      state_q;
  logic [AZ_W-1:0] az_q;
  logic [15:0]     timeout_q;
  logic            rev_err_q;
  logic            acp_lost_q;

  logic            sweep_start_q;
  logic [AZ_W-1:0] sweep_az_q;
  logic [9:0]      bin_q;
  logic [15:0]     div_q;
  logic            valid_q;

  logic timeout_hit;
  logic trig_accept;

  // Loss of lock takes priority over a coincident trigger.
  assign timeout_hit = (state_q == LOCKED) && !acp_ev && (timeout_q == TIMEOUT_LAST);
  assign trig_accept = (state_q == LOCKED) && trig_ev && !timeout_hit;

  // Azimuth tracker FSM with ACP-loss timeout; ARP dominates ACP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SEARCH;
      az_q       <= '0;
      timeout_q  <= 16'd0;
      rev_err_q  <= 1'b0;
      acp_lost_q <= 1'b0;
    end else begin
      rev_err_q  <= 1'b0;
      acp_lost_q <= 1'b0;
      case (state_q)
        SEARCH: begin
          az_q      <= '0;
          timeout_q <= 16'd0;
          if (arp_ev) begin
            state_q <= LOCKED;
          end else begin
            state_q <= SEARCH;
          end
        end
        LOCKED: begin
          if (timeout_hit) begin
            acp_lost_q <= 1'b1;
            state_q    <= SEARCH;
            az_q       <= '0;
            timeout_q  <= 16'd0;
          end else begin
            timeout_q <= acp_ev ? 16'd0 : (timeout_q + 16'd1);
            if (arp_ev) begin
              az_q      <= '0;
              rev_err_q <= (az_q != AZ_LAST);
            end else if (acp_ev) begin
              az_q <= az_q + 12'd1;
            end else begin
              az_q <= az_q;
            end
          end
        end
        default: begin
          state_q   <= SEARCH;
          az_q      <= '0;
          timeout_q <= 16'd0;
        end
      endcase
    end
  end

  // Range sweep: restart on accepted trigger, step every RANGE_DIV cycles, stop after the last bin.
  always_ff @(posedge clk) begin
    if (rst) begin
      sweep_start_q <= 1'b0;
      sweep_az_q    <= '0;
      bin_q         <= 10'd0;
      div_q         <= 16'd0;
      valid_q       <= 1'b0;
    end else begin
      sweep_start_q <= 1'b0;
      if (timeout_hit) begin
        valid_q <= 1'b0;
      end else if (trig_accept) begin
        sweep_start_q <= 1'b1;
        sweep_az_q    <= az_q;
        bin_q         <= 10'd0;
        div_q         <= 16'd0;
        valid_q       <= 1'b1;
      end else if (valid_q) begin
        if (div_q == DIV_LAST) begin
          div_q <= 16'd0;
          if (bin_q == BIN_LAST) begin
            valid_q <= 1'b0;
          end else begin
            bin_q <= bin_q + 10'd1;
          end
        end else begin
          div_q <= div_q + 16'd1;
        end
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef RADAR_RX_PERIOD_MEAS_EN
  logic [15:0] per_cnt_q;
  logic [15:0] per_q;
  logic [15:0] per_cnt_inc;

  assign per_cnt_inc = (per_cnt_q == 16'hFFFF) ? 16'hFFFF : (per_cnt_q + 16'd1);

  // Saturating cycle count between ACP events, loaded into acp_period on each event.
  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt_q <= 16'd0;
      per_q     <= 16'd0;
    end else if (acp_ev) begin
      per_cnt_q <= 16'd0;
      per_q     <= per_cnt_inc;
    end else begin
      per_cnt_q <= per_cnt_inc;
      per_q     <= per_q;
    end
  end

  assign acp_period = per_q;
`else
  assign acp_period = 16'd0;
`endif

  assign locked      = (state_q == LOCKED);
  assign azimuth     = az_q;
  assign sweep_start = sweep_start_q;
  assign sweep_az    = sweep_az_q;
  assign range_bin   = bin_q;
  assign range_valid = valid_q;
  assign rev_err     = rev_err_q;
  assign acp_lost    = acp_lost_q;

endmodule

// File: doc/radar_if_rx.md
RADAR_IF_RX -- requirements
Module: radar_if_rx

Interface
REQ-001 Parameter RANGE_DIV, default 24, clk cycles per range bin.
REQ-002 Parameter RANGE_BINS, default 1000, range bins per sweep; at most 1024.
REQ-003 Parameter ACP_TIMEOUT, default 49000, clk cycles without an ACP edge before lock is lost; fits in 16 bits.
REQ-004 clk  input  1  system clock, 50 MHz; the only clock.
REQ-005 rst  input  1  reset, synchronous to clk, active-high.
REQ-006 arp  input  1  Azimuth Reset Pulse; asynchronous to clk.
REQ-007 acp  input  1  Azimuth Change Pulse; asynchronous to clk.
REQ-008 trig  input  1  master trigger; asynchronous to clk.
REQ-009 locked  output  1  high while the azimuth tracker is in LOCKED.
REQ-010 azimuth  output  12  current azimuth in ACP steps, 0..4095.
REQ-011 sweep_start  output  1  one-cycle pulse at each accepted trigger.
REQ-012 sweep_az  output  12  azimuth latched at the last sweep_start.
REQ-013 range_bin  output  10  current range bin index.
REQ-014 range_valid  output  1  high while range_bin is valid within a sweep.
REQ-015 rev_err  output  1  one-cycle pulse when an ARP arrives with an ACP count not equal to 4096.
REQ-016 acp_lost  output  1  one-cycle pulse when ACP_TIMEOUT expires.
REQ-017 acp_period  output  16  clk cycles between the last two ACP rising edges.

Function
REQ-018 Each of arp, acp and trig SHALL pass through a two-flop synchronizer followed by rising-edge detection, so an input rising edge produces an internal event pulse exactly 3 clk cycles later.
REQ-019 The tracker SHALL have two states: SEARCH and LOCKED; locked = (state == LOCKED).
REQ-020 SEARCH: azimuth held at 0; an ARP event moves the tracker to LOCKED with azimuth = 0; ACP events are ignored.
REQ-021 LOCKED: an ACP event without an ARP event SHALL increment azimuth modulo 4096, wrapping from 4095 to 0.
REQ-022 LOCKED: an ARP event, with or without a coincident ACP event, SHALL set azimuth to 0; ARP dominates ACP.
REQ-023 LOCKED: if an ARP event arrives while azimuth != 4095, rev_err SHALL pulse in the same cycle as the resync; the tracker remains in LOCKED.
REQ-024 A timeout counter SHALL clear on every ACP event and on entry to LOCKED; on reaching ACP_TIMEOUT in LOCKED it SHALL pulse acp_lost and move the tracker to SEARCH with azimuth = 0.
REQ-025 A trig event in LOCKED SHALL pulse sweep_start, latch sweep_az = azimuth (the pre-update value in that cycle), set range_bin = 0 and set range_valid = 1.
REQ-026 A trig event in SEARCH SHALL be ignored, with no sweep_start.
REQ-027 During a sweep, range_bin SHALL increment once every RANGE_DIV cycles; after bin RANGE_BINS-1 has been held for RANGE_DIV cycles, range_valid SHALL drop and range_bin SHALL hold.
REQ-028 A trig event during an active sweep SHALL restart the sweep at bin 0, with no gap in range_valid.
REQ-029 Loss of lock (the LOCKED to SEARCH transition) SHALL drop range_valid in the same cycle.

Reset
REQ-030 While rst is high at a clk edge, the block SHALL enter SEARCH and clear all synchronizer flops, counters, azimuth, sweep_az, range_bin and acp_period to 0.
REQ-031 During reset, locked, range_valid, sweep_start, rev_err and acp_lost SHALL be 0.
REQ-032 An assertion of rst in mid-sweep or mid-revolution SHALL abandon that sweep or revolution; after release, no event SHALL be generated from input levels that were already high.

Configuration
REQ-033 With RADAR_RX_PERIOD_MEAS_EN defined, a 16-bit counter SHALL count clk cycles between ACP events, saturating at 65535, and load acp_period on each ACP event.
REQ-034 Without RADAR_RX_PERIOD_MEAS_EN, acp_period SHALL be constant 0 and no period counter SHALL be synthesized.

Structure
REQ-035 A shared package radar_pkg SHALL hold AZ_W = 12, ACP_PER_REV = 4096 and the tracker state type {SEARCH, LOCKED}.
REQ-036 Sub-module edge_sync (two-flop synchronizer plus rising-edge pulse) SHALL be instantiated once each for arp, acp and trig.

Verification
REQ-037 Reset, then drive ARP coincident with ACP, then 4095 further ACPs, then ARP with ACP -> locked = 1, azimuth walks 0..4095 then returns to 0, and rev_err never pulses.
REQ-038 While LOCKED, drive ARP after only 100 ACPs -> exactly one rev_err pulse and azimuth = 0.
REQ-039 While LOCKED at azimuth 37, drive trig -> sweep_start pulses 3 cycles after the trig edge, sweep_az = 37, range_bin steps every 24 cycles, and range_valid stays high for 24000 cycles.
REQ-040 Drive trig while in SEARCH -> no sweep_start and range_valid stays 0.
REQ-041 While LOCKED, stop ACP -> acp_lost pulses after 49000 cycles, then locked = 0 and range_valid = 0.
REQ-042 With RADAR_RX_PERIOD_MEAS_EN defined, drive ACP edges 24412 cycles apart -> acp_period = 24412; without the macro -> acp_period = 0.
